led_step_counter: RTL and testbench
===================================

# led_step_counter

Parametrised LED step counter for the 27 MHz board clock. It replaces the derived slow-clock scheme with a single-clock design: a clock-enable tick generator, a WIDTH-bit up/down LED counter with wrap detection, a debounced button that toggles run/pause, and a square-wave buzzer that sounds while the button is held and for a fixed time after each wrap. It drives the board LEDs and the buzzer pin directly.

## Interface
- CLK_HZ, 27_000_000, input clock frequency in Hz
- TICK_HZ, 1, counter step rate; DIV = CLK_HZ/TICK_HZ, which must be an integer ≥2
- WIDTH, 4, LED counter width (1..16)
- DEBOUNCE_CYCLES, 270_000, stable-input cycles required to accept a button change (≥1)
- TONE_HALF, 125_000, buzzer half-period in clk cycles (≥1)
- BEEP_CYCLES, 2_700_000, buzzer duration after a wrap event (≥1)

- clk  in  1  board clock
- rst_n  in  1  asynchronous active-low reset
- press  in  1  raw push-button, active-high, asynchronous to clk, may bounce
- dir  in  1  count direction: 1 = up, 0 = down; sampled on each tick
- clear  in  1  synchronous clear of the counter and tick divider
- led  out  WIDTH  current count
- tick  out  1  one-cycle pulse on each counter step
- wrap  out  1  one-cycle pulse when the counter wraps
- running  out  1  1 = RUN, 0 = PAUSE
- press_db  out  1  debounced button level
- sound  out  1  buzzer square wave

## Operation
- Reset (rst_n low, asynchronous): led=0, tick=0, wrap=0, sound=0, press_db=0, running=1 (RUN). All internal counters, the synchroniser and the beep timer are cleared.
- Tick divider: a counter runs from 0 to DIV-1 and then returns to 0. It advances only in RUN and holds its value in PAUSE. A step occurs on the edge where the divider moves from DIV-1 to 0.
- On a step:
  - Up mode: led <= led+1, modulo 2^WIDTH. wrap is asserted when the old value is all-ones.
  - Down mode: led <= led-1, modulo 2^WIDTH. wrap is asserted when the old value is 0.
- clear (synchronous): led <= 0 and divider <= 0. clear overrides a step on the same edge: no tick and no wrap are produced. clear does not change the RUN/PAUSE state or the beep timer.
- Button path:
  - A 2-flop synchroniser feeds a stability counter.
  - When the synchronised level differs from press_db for DEBOUNCE_CYCLES consecutive cycles, press_db takes the new level.
  - Any return to the press_db level before then resets the stability counter.
- State machine (RUN/PAUSE): each rising edge of press_db toggles the state on the next edge. A falling edge has no effect.
- Beep timer:
  - A wrap loads BEEP_CYCLES. A new wrap reloads the timer even if it is nonzero.
  - Otherwise the timer decrements to 0 and then holds.
- Buzzer:
  - beep_on = press_db OR (beep timer ≠ 0).
  - While beep_on, a tone counter toggles sound every TONE_HALF cycles. The first toggle comes TONE_HALF cycles after beep_on rises.
  - While beep_on is low, sound=0 and the tone counter is held at 0.

## Timing
- All outputs are registered.
- tick, wrap and the new led value appear together, in the cycle after the divider's DIV-1 cycle. tick and wrap are exactly one cycle wide.
- In continuous RUN, the step period is exactly DIV cycles. PAUSE stretches the period by exactly the number of paused cycles, with no phase loss.
- press_db latency: 2 synchroniser cycles + DEBOUNCE_CYCLES + 1 cycles after press changes cleanly. running toggles 1 cycle after press_db rises.
- A press_db rise in the same cycle as the divider's DIV-1 cycle: the step still occurs, then the state changes to PAUSE.
- The beep timer loads on the edge where wrap is asserted, so sound is active for BEEP_CYCLES cycles after that edge.
- Reset asserted mid-operation takes effect immediately on all outputs. After release, the first step occurs DIV cycles later.

## Test plan
Unless a scenario says otherwise, all benches use CLK_HZ=100, TICK_HZ=10 (DIV=10), WIDTH=3, DEBOUNCE_CYCLES=4, TONE_HALF=2, BEEP_CYCLES=8.

1. Reset, dir=1, clear=0, press=0 for 80 cycles:
   - tick pulses every 10 cycles.
   - led steps 0,1,…,7,0.
   - wrap is a single pulse on the 7→0 step, coincident with tick.
2. Down count:
   - From reset with dir=0, the first step gives led 0→7 with wrap=1.
   - Flip dir to 1 mid-interval: the next step increments.
3. Debounce:
   - press toggles every 2 cycles for 20 cycles, then stays high: press_db rises 2+4+1 cycles after the last transition, and running goes 1→0 one cycle later.
   - While paused, led is frozen; on the resume press, the remaining divider count completes.
4. clear:
   - Assert clear on the divider's DIV-1 cycle with led=7, dir=1: led=0, tick=0, wrap=0.
   - The next tick comes 10 cycles later with led=1.
5. Buzzer:
   - After a wrap, sound toggles every 2 cycles for 8 cycles, then stays 0.
   - Holding press_db high keeps the tone running; release with the timer at 0 forces sound=0 next cycle.
   - A second wrap during the beep restarts the 8-cycle window.
6. Reset mid-beep and mid-interval:
   - All outputs return to their reset values asynchronously, and running=1.
   - After release, the first tick arrives exactly 10 cycles later with led=1.

Source files
------------

// File: rtl/led_step_counter_if.sv
// led_step_counter_if: groups the LED step counter's control inputs and status outputs.
//   press    : raw push-button, active-high, asynchronous, may bounce
//   dir      : count direction (1 = up, 0 = down)
//   clear    : synchronous clear of counter and tick divider
//   led      : current count (WIDTH bits)
//   tick     : one-cycle pulse on each counter step
//   wrap     : one-cycle pulse when the counter wraps
//   running  : 1 = RUN, 0 = PAUSE
//   press_db : debounced button level
//   sound    : buzzer square wave
// master drives the inputs (board / testbench), slave is the counter itself.
interface led_step_counter_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             press;
  logic             dir;
  logic             clear;
  logic [WIDTH-1:0] led;
  logic             tick;
  logic             wrap;
  logic             running;
  logic             press_db;
  logic             sound;

  modport master (
    output press, dir, clear,
    input  led, tick, wrap, running, press_db, sound
  );

  modport slave (
    input  press, dir, clear,
    output led, tick, wrap, running, press_db, sound
  );
endinterface

// File: rtl/led_step_counter.sv
// led_step_counter: single-clock LED step counter with clock-enable tick divider, up/down
// counter with wrap detection, debounced run/pause button and square-wave buzzer.
//   clk    : board clock (CLK_HZ)
//   rst_n  : asynchronous active-low reset
//   io_bus : led_step_counter_if slave (press/dir/clear in; led/tick/wrap/running/
//            press_db/sound out, all registered)
module led_step_counter #(
  parameter int unsigned CLK_HZ          = 27_000_000,
  parameter int unsigned TICK_HZ         = 1,
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 270_000,
  parameter int unsigned TONE_HALF       = 125_000,
  parameter int unsigned BEEP_CYCLES     = 2_700_000
) (
  input  logic               clk,
  input  logic               rst_n,
  led_step_counter_if.slave  io_bus
);
  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned DivW  = $clog2(DIV);
  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned ToneW = $clog2(TONE_HALF + 1);
  localparam int unsigned BeepW = $clog2(BEEP_CYCLES + 1);

  typedef enum logic {StPause = 1'b0, StRun = 1'b1} state_e;

  state_e           r_state;
  logic [DivW-1:0]  r_div;
  logic [WIDTH-1:0] r_led;
  logic             r_tick;
  logic             r_wrap;
  logic [1:0]       r_sync;
  logic [DbW-1:0]   r_db_cnt;
  logic             r_press_db;
  logic             r_press_db_q;
  logic [BeepW-1:0] r_beep;
  logic [ToneW-1:0] r_tone;
  logic             r_sound;

  logic w_running, w_div_last, w_step, w_wrap, w_db_rise, w_beep_on, w_tone_last;

  assign w_running   = (r_state == StRun);
  assign w_div_last  = (r_div == DivW'(DIV - 1));
  // clear wins over a step on the same edge
  assign w_step      = w_running & w_div_last & ~io_bus.clear;
  assign w_wrap      = w_step & (io_bus.dir ? (&r_led) : ~(|r_led));
  assign w_db_rise   = r_press_db & ~r_press_db_q;
  assign w_beep_on   = r_press_db | (|r_beep);
  assign w_tone_last = (r_tone == ToneW'(TONE_HALF - 1));

  // Tick divider and LED counter; divider holds while paused so no phase is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_led  <= '0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_tick <= w_step;
      r_wrap <= w_wrap;
      if (io_bus.clear) begin
        r_div <= '0;
        r_led <= '0;
      end else begin
        if (w_running) begin
          r_div <= w_div_last ? '0 : r_div + DivW'(1);
        end
        if (w_step) begin
          r_led <= io_bus.dir ? r_led + WIDTH'(1) : r_led - WIDTH'(1);
        end
      end
    end
  end

  // Synchroniser and debounce: the new level must be seen DEBOUNCE_CYCLES+1 samples in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync       <= 2'b00;
      r_db_cnt     <= '0;
      r_press_db   <= 1'b0;
      r_press_db_q <= 1'b0;
    end else begin
      r_sync       <= {r_sync[0], io_bus.press};
      r_press_db_q <= r_press_db;
      if (r_sync[1] == r_press_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DbW'(DEBOUNCE_CYCLES)) begin
        r_press_db <= r_sync[1];
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DbW'(1);
      end
    end
  end

  // RUN/PAUSE state machine, toggled by each debounced rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StRun;
    end else begin
      case (r_state)
        StRun:   if (w_db_rise) r_state <= StPause;
        StPause: if (w_db_rise) r_state <= StRun;
        default: r_state <= StRun;
      endcase
    end
  end

  // Beep timer and tone generator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beep  <= '0;
      r_tone  <= '0;
      r_sound <= 1'b0;
    end else begin
      if (w_wrap) begin
        r_beep <= BeepW'(BEEP_CYCLES);
      end else if (|r_beep) begin
        r_beep <= r_beep - BeepW'(1);
      end
      if (!w_beep_on) begin
        r_tone  <= '0;
        r_sound <= 1'b0;
      end else if (w_tone_last) begin
        r_tone  <= '0;
        r_sound <= ~r_sound;
      end else begin
        r_tone <= r_tone + ToneW'(1);
      end
    end
  end

  assign io_bus.led      = r_led;
  assign io_bus.tick     = r_tick;
  assign io_bus.wrap     = r_wrap;
  assign io_bus.running  = w_running;
  assign io_bus.press_db = r_press_db;
  assign io_bus.sound    = r_sound;
endmodule

// File: tb/tb_led_step_counter.sv
// tb_led_step_counter: directed scenarios plus randomized stimulus, every cycle compared
// against a behavioural model of the counter, debounce window, beep timer and tone.
module tb_led_step_counter;
  localparam int unsigned CLK_HZ = 100;
  localparam int unsigned TICK_HZ = 10;
  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned WIDTH = 3;
  localparam int unsigned DB = 4;
  localparam int unsigned TH = 2;
  localparam int unsigned BC = 8;
  localparam int MODV = 1 << WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  led_step_counter_if #(.WIDTH(WIDTH)) bus_if ();

  led_step_counter #(
    .CLK_HZ          (CLK_HZ),
    .TICK_HZ         (TICK_HZ),
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DB),
    .TONE_HALF       (TH),
    .BEEP_CYCLES     (BC)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int m_runcyc, m_led, m_tick, m_wrap, m_running, m_db, m_db_prev, m_beep, m_age, m_sound;
  bit p_hist[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_runcyc = 0; m_led = 0; m_tick = 0; m_wrap = 0; m_running = 1;
    m_db = 0; m_db_prev = 0; m_beep = 0; m_age = 0; m_sound = 0;
    p_hist.delete();
    for (int i = 0; i < DB + 3; i++) p_hist.push_back(1'b0);
  endtask

  task automatic model_edge();
    bit step, wrp, on_pre, flip, clr, up;
    int len;
    clr = bus_if.clear;
    up = bus_if.dir;
    on_pre = (m_db != 0) || (m_beep != 0);
    step = (m_running != 0) && !clr && (((m_runcyc + 1) % DIV) == 0);
    wrp = step && (up ? (m_led == MODV - 1) : (m_led == 0));
    // press level that reached the debouncer at each of the last DB+1 edges
    len = p_hist.size();
    flip = 1'b1;
    for (int k = 0; k <= DB; k++) if (int'(p_hist[len - 2 - k]) == m_db) flip = 1'b0;
    if (clr) m_runcyc = 0;
    else if (m_running != 0) m_runcyc++;
    if (clr) m_led = 0;
    else if (step) m_led = (m_led + (up ? 1 : MODV - 1)) % MODV;
    m_tick = step;
    m_wrap = wrp;
    if (m_db != 0 && m_db_prev == 0) m_running = 1 - m_running;
    m_db_prev = m_db;
    if (flip) m_db = 1 - m_db;
    p_hist.push_back(bus_if.press);
    if (p_hist.size() > DB + 4) void'(p_hist.pop_front());
    m_age = on_pre ? m_age + 1 : 0;
    m_sound = on_pre ? ((m_age / TH) % 2) : 0;
    m_beep = wrp ? BC : (m_beep > 0 ? m_beep - 1 : 0);
  endtask

  task automatic compare_all();
    check_eq("led", bus_if.led, m_led);
    check_eq("tick", bus_if.tick, m_tick);
    check_eq("wrap", bus_if.wrap, m_wrap);
    check_eq("running", bus_if.running, m_running);
    check_eq("press_db", bus_if.press_db, m_db);
    check_eq("sound", bus_if.sound, m_sound);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    compare_all();
  endtask

  // Called at posedge+1; asserts reset mid-cycle and releases it mid-cycle two edges later.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_led", bus_if.led, 0);
    check_eq("rst_tick", bus_if.tick, 0);
    check_eq("rst_wrap", bus_if.wrap, 0);
    check_eq("rst_running", bus_if.running, 1);
    check_eq("rst_press_db", bus_if.press_db, 0);
    check_eq("rst_sound", bus_if.sound, 0);
    model_reset();
    cycle();
    cycle();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_t, n_w, lat, frozen, hold, lvl;
    bus_if.press = 1'b0;
    bus_if.dir   = 1'b1;
    bus_if.clear = 1'b0;
    model_reset();

    // 1: free-running up count
    async_reset();
    n_t = 0; n_w = 0;
    for (int c = 1; c <= 80; c++) begin
      cycle();
      if (bus_if.tick === 1'b1) begin
        n_t++;
        check_eq("s1_phase", c % DIV, 0);
        check_eq("s1_ledseq", bus_if.led, n_t % MODV);
      end
      if (bus_if.wrap === 1'b1) begin
        n_w++;
        check_eq("s1_wrap_tick", bus_if.tick, 1);
      end
    end
    check_eq("s1_ticks", n_t, 8);
    check_eq("s1_wraps", n_w, 1);

    // 2: down count, then direction flip mid-interval
    bus_if.dir = 1'b0;
    async_reset();
    repeat (10) cycle();
    check_eq("s2_down_led", bus_if.led, 7);
    check_eq("s2_down_wrap", bus_if.wrap, 1);
    repeat (5) cycle();
    bus_if.dir = 1'b1;
    repeat (5) cycle();
    check_eq("s2_flip_tick", bus_if.tick, 1);
    check_eq("s2_flip_led", bus_if.led, 0);

    // 3: bouncing press, pause, resume
    async_reset();
    repeat (3) cycle();
    for (int i = 0; i < 10; i++) begin
      bus_if.press = ~bus_if.press;
      repeat (2) cycle();
    end
    bus_if.press = 1'b1;
    lat = 0;
    while (bus_if.press_db !== 1'b1 && lat < 30) begin
      cycle();
      lat++;
    end
    check_eq("s3_db_latency", lat, 2 + DB + 1);
    check_eq("s3_still_run", bus_if.running, 1);
    cycle();
    check_eq("s3_paused", bus_if.running, 0);
    frozen = int'(bus_if.led);
    repeat (15) cycle();
    check_eq("s3_frozen", bus_if.led, frozen);
    bus_if.press = 1'b0;
    repeat (12) cycle();
    bus_if.press = 1'b1;
    repeat (9) cycle();
    check_eq("s3_resumed", bus_if.running, 1);
    repeat (20) cycle();
    bus_if.press = 1'b0;
    repeat (12) cycle();

    // 4: clear on the DIV-1 cycle with led=7
    async_reset();
    repeat (79) cycle();
    check_eq("s4_pre_led", bus_if.led, 7);
    bus_if.clear = 1'b1;
    cycle();
    bus_if.clear = 1'b0;
    check_eq("s4_clr_led", bus_if.led, 0);
    check_eq("s4_clr_tick", bus_if.tick, 0);
    check_eq("s4_clr_wrap", bus_if.wrap, 0);
    repeat (10) cycle();
    check_eq("s4_next_tick", bus_if.tick, 1);
    check_eq("s4_next_led", bus_if.led, 1);

    // 5: beep after wrap, then held press tone
    async_reset();
    repeat (80) cycle();
    check_eq("s5_wrap", bus_if.wrap, 1);
    for (int k = 1; k <= 12; k++) begin
      cycle();
      check_eq("s5_tone", bus_if.sound, (k <= int'(BC)) ? ((k / TH) % 2) : 0);
    end
    bus_if.press = 1'b1;
    repeat (30) cycle();
    bus_if.press = 1'b0;
    repeat (15) cycle();
    check_eq("s5_quiet", bus_if.sound, 0);

    // 6: reset mid-beep and mid-interval
    bus_if.dir = 1'b1;
    async_reset();
    repeat (83) cycle();
    async_reset();
    repeat (9) cycle();
    check_eq("s6_no_early_tick", bus_if.tick, 0);
    cycle();
    check_eq("s6_tick", bus_if.tick, 1);
    check_eq("s6_led", bus_if.led, 1);

    // Randomized phase
    hold = 0; lvl = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        lvl = int'($urandom_range(0, 1));
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                           : int'($urandom_range(5, 40));
      end
      hold--;
      bus_if.press = lvl[0];
      if ($urandom_range(0, 99) < 3) bus_if.dir = ~bus_if.dir;
      bus_if.clear = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 999) < 3) begin
        bus_if.clear = 1'b0;
        async_reset();
      end else begin
        cycle();
      end
    end
    bus_if.clear = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
